// File: rtl/aval_pkg.sv
// Shared types and helpers for the avalanche scan controller.
package aval_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StRun,
    StCmp,
    StEmit,
    StDone
  } state_e;

  localparam logic BASE = 1'b0;
  localparam logic FLIP = 1'b1;

  localparam int unsigned PopMaxW = 128;

  // $clog2 that never returns 0, so single-entry indices still get one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] popcount(input logic [PopMaxW-1:0] v, input int unsigned width);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < PopMaxW; i++) begin
      if (i < width) cnt = cnt + 8'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/avalanche_scan_ctrl_if.sv
// Request/response bundle between the scan controller and a block-cipher core.
interface avalanche_scan_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEY_W  = 64
) ();

  logic              core_enable;
  logic              core_mode;
  logic [DATA_W-1:0] core_data;
  logic [KEY_W-1:0]  core_key;
  logic [DATA_W-1:0] core_result;
  logic              core_ready;

  modport master (
    output core_enable,
    output core_mode,
    output core_data,
    output core_key,
    input  core_result,
    input  core_ready
  );

  modport slave (
    input  core_enable,
    input  core_mode,
    input  core_data,
    input  core_key,
    output core_result,
    output core_ready
  );

endinterface

// File: rtl/popcount_tree.sv
// Registered binary adder tree counting set bits; one-cycle latency, loads when en_i is high.
module popcount_tree #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam int unsigned Leaves = 1 << $clog2(DATA_W);
  localparam int unsigned Nodes  = 2 * Leaves - 1;

  logic [CNT_W-1:0] node [Nodes];
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Heap-ordered tree: node k sums children 2k+1 and 2k+2, leaves sit at Leaves-1 onwards.
  always_comb begin
    for (int i = 0; i < int'(Nodes); i++) node[i] = '0;
    for (int i = 0; i < int'(DATA_W); i++) node[int'(Leaves) - 1 + i] = CNT_W'(data_i[i]);
    for (int k = int'(Leaves) - 2; k >= 0; k--) node[k] = node[2 * k + 1] + node[2 * k + 2];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = node[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/avalanche_scan_ctrl.sv
// Avalanche analyser: runs a cipher core on a base block and every single-bit flip of it.
// Optional key-bit scanning is compiled in with AVAL_KEY_SCAN_EN.
module avalanche_scan_ctrl
  import aval_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned KEY_W   = 64,
  parameter int unsigned CNT_W   = $clog2(DATA_W + 1),
  parameter int unsigned TOT_W   = 16,
  parameter int unsigned RST_GAP = 2,
`ifdef AVAL_KEY_SCAN_EN
  localparam int unsigned IdxW = clog2_min1((DATA_W > KEY_W) ? DATA_W : KEY_W)
`else
  localparam int unsigned IdxW = clog2_min1(DATA_W)
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [DATA_W-1:0]      base_data_i,
  input  logic [KEY_W-1:0]       key_i,
`ifdef AVAL_KEY_SCAN_EN
  input  logic                   scan_key_i,
`endif
  avalanche_scan_ctrl_if.master  core,
  output logic [DATA_W-1:0]      base_out_o,
  output logic                   res_valid_o,
  output logic [IdxW-1:0]        res_idx_o,
  output logic [CNT_W-1:0]       res_cnt_o,
  output logic [TOT_W-1:0]       total_o,
  output logic [CNT_W-1:0]       min_o,
  output logic [CNT_W-1:0]       max_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned SumW = TOT_W + 1;

  state_e            state_d, state_q;
  logic              phase_d, phase_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [3:0]        gap_d, gap_q;
  logic              mode_d, mode_q;
  logic [DATA_W-1:0] base_d, base_q;
  logic [KEY_W-1:0]  key_d, key_q;
  logic [DATA_W-1:0] cap_d, cap_q;
  logic [DATA_W-1:0] base_out_d, base_out_q;
  logic [TOT_W-1:0]  total_d, total_q;
  logic [CNT_W-1:0]  min_d, min_q;
  logic [CNT_W-1:0]  max_d, max_q;
  logic              key_scan;
  logic              pop_en;
  logic [CNT_W-1:0]  res_cnt;
  logic [SumW-1:0]   tot_sum;
  logic [IdxW-1:0]   last_idx;
  logic [DATA_W-1:0] data_mask;
  logic [KEY_W-1:0]  key_mask;

`ifdef AVAL_KEY_SCAN_EN
  logic key_scan_d, key_scan_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) key_scan_q <= 1'b0;
    else        key_scan_q <= key_scan_d;
  end
  always_comb begin
    key_scan_d = key_scan_q;
    if (state_q == StIdle && start_i) key_scan_d = scan_key_i;
  end
  assign key_scan = key_scan_q;
`else
  assign key_scan = 1'b0;
`endif

  assign last_idx  = key_scan ? IdxW'(KEY_W - 1) : IdxW'(DATA_W - 1);
  assign data_mask = (phase_q == FLIP && !key_scan) ? (DATA_W'(1) << idx_q) : '0;
  assign key_mask  = (phase_q == FLIP && key_scan) ? (KEY_W'(1) << idx_q) : '0;
  assign tot_sum   = {1'b0, total_q} + SumW'(res_cnt);

  popcount_tree #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_popcount_tree (
    .clk    (clk),
    .reset  (reset),
    .en_i   (pop_en),
    .data_i (cap_q ^ base_out_q),
    .cnt_o  (res_cnt)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    mode_d     = mode_q;
    base_d     = base_q;
    key_d      = key_q;
    cap_d      = cap_q;
    base_out_d = base_out_q;
    total_d    = total_q;
    min_d      = min_q;
    max_d      = max_q;
    pop_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = mode_i;
          base_d  = base_data_i;
          key_d   = key_i;
          idx_d   = '0;
          phase_d = BASE;
          total_d = '0;
          max_d   = '0;
          min_d   = '1;
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == 4'(RST_GAP - 1)) state_d = StRun;
        else                          gap_d   = gap_q + 4'd1;
      end
      StRun: begin
        if (core.core_ready) begin
          cap_d   = core.core_result;
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (phase_q == BASE) begin
          base_out_d = cap_q;
          phase_d    = FLIP;
          gap_d      = '0;
          state_d    = StGap;
        end else begin
          pop_en  = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        total_d = tot_sum[SumW-1] ? '1 : tot_sum[TOT_W-1:0];
        if (res_cnt < min_q) min_d = res_cnt;
        if (res_cnt > max_q) max_d = res_cnt;
        if (idx_q == last_idx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      phase_q    <= BASE;
      idx_q      <= '0;
      gap_q      <= '0;
      mode_q     <= 1'b0;
      base_q     <= '0;
      key_q      <= '0;
      cap_q      <= '0;
      base_out_q <= '0;
      total_q    <= '0;
      min_q      <= '1;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      key_q      <= key_d;
      cap_q      <= cap_d;
      base_out_q <= base_out_d;
      total_q    <= total_d;
      min_q      <= min_d;
      max_q      <= max_d;
    end
  end

  assign core.core_enable = (state_q == StRun);
  assign core.core_mode   = mode_q;
  assign core.core_data   = base_q ^ data_mask;
  assign core.core_key    = key_q ^ key_mask;

  assign base_out_o  = base_out_q;
  assign res_valid_o = (state_q == StEmit);
  assign res_idx_o   = idx_q;
  assign res_cnt_o   = res_cnt;
  assign total_o     = total_q;
  assign min_o       = min_q;
  assign max_o       = max_q;
  assign busy_o      = (state_q == StGap) || (state_q == StRun) ||
                       (state_q == StCmp) || (state_q == StEmit);
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_avalanche_scan_ctrl.sv
// Randomised bench for avalanche_scan_ctrl against a behavioural avalanche model.
module tb_avalanche_scan_ctrl;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEY_W   = 64;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned TOT_W   = 16;
  localparam int unsigned RST_GAP = 3;
  localparam int unsigned IDX_W   = 6;

  typedef struct {
    int idx;
    int cnt;
  } res_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start_i = 1'b0;
  logic              mode_i = 1'b0;
  logic [DATA_W-1:0] base_data_i = '0;
  logic [KEY_W-1:0]  key_i = '0;
  logic [DATA_W-1:0] base_out_o;
  logic              res_valid_o;
  logic [IDX_W-1:0]  res_idx_o;
  logic [CNT_W-1:0]  res_cnt_o;
  logic [TOT_W-1:0]  total_o;
  logic [CNT_W-1:0]  min_o;
  logic [CNT_W-1:0]  max_o;
  logic              busy_o;
  logic              done_o;
`ifdef AVAL_KEY_SCAN_EN
  logic              scan_key_i = 1'b0;
`endif

  avalanche_scan_ctrl_if #(.DATA_W(DATA_W), .KEY_W(KEY_W)) core_bus ();

  avalanche_scan_ctrl #(
    .DATA_W  (DATA_W),
    .KEY_W   (KEY_W),
    .CNT_W   (CNT_W),
    .TOT_W   (TOT_W),
    .RST_GAP (RST_GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .base_data_i (base_data_i),
    .key_i       (key_i),
`ifdef AVAL_KEY_SCAN_EN
    .scan_key_i  (scan_key_i),
`endif
    .core        (core_bus),
    .base_out_o  (base_out_o),
    .res_valid_o (res_valid_o),
    .res_idx_o   (res_idx_o),
    .res_cnt_o   (res_cnt_o),
    .total_o     (total_o),
    .min_o       (min_o),
    .max_o       (max_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Core model controls
  int fn_sel = 0;
  int lat = 2;
  bit gap_noise = 1'b0;
  int en_cnt = 0;

  // Scan model
  logic [DATA_W-1:0] m_base, m_key;
  logic              m_mode;
  res_t              exp_q[$];
  int                exp_total;
  int                mtot, mmin, mmax;
  int                run_no, low_cnt, high_cnt, ndone;
  bit                chk_en = 1'b0;

  function automatic logic [63:0] core_f(input int sel, input logic [63:0] x, input logic [63:0] k);
    logic [63:0] y;
    case (sel)
      0:       y = x;
      1:       y = ~x;
      2:       y = x ^ k;
      default: begin
        y = x * 64'h9E3779B97F4A7C15;
        y = y ^ (y >> 29);
        y = y ^ k;
      end
    endcase
    return y;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core: result valid lat+1 cycles into enable; garbage (and optional stray ready) when idle.
  initial begin
    core_bus.core_ready  = 1'b0;
    core_bus.core_result = '0;
  end
  always @(posedge clk) begin
    #1;
    if (core_bus.core_enable) begin
      en_cnt++;
      core_bus.core_ready  = (en_cnt > lat);
      core_bus.core_result = core_f(fn_sel, core_bus.core_data, core_bus.core_key);
    end else begin
      en_cnt = 0;
      core_bus.core_ready  = gap_noise && ($urandom_range(0, 1) == 1);
      core_bus.core_result = {$urandom, $urandom};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("total", total_o, mtot);
      chk("min", min_o, mmin);
      chk("max", max_o, mmax);
      if (res_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("extra_result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_idx", res_idx_o, e.idx);
          chk("res_cnt", res_cnt_o, e.cnt);
          chk("base_out", base_out_o, core_f(fn_sel, m_base, m_key));
          mtot = (mtot + e.cnt > 65535) ? 65535 : mtot + e.cnt;
          if (e.cnt < mmin) mmin = e.cnt;
          if (e.cnt > mmax) mmax = e.cnt;
        end
      end
      if (done_o) begin
        ndone++;
        chk("done_all_results", exp_q.size(), 0);
        chk("busy_at_done", busy_o, 0);
      end
      if (core_bus.core_enable) begin
        if (high_cnt == 0) begin
          chk("gap_len", low_cnt, RST_GAP + ((run_no == 0) ? 0 : (run_no == 1) ? 1 : 2));
        end
        high_cnt++;
        low_cnt = 0;
        chk("core_data", core_bus.core_data,
            (run_no == 0) ? m_base : (m_base ^ (64'd1 << (run_no - 1))));
        chk("core_key", core_bus.core_key, m_key);
        chk("core_mode", core_bus.core_mode, m_mode);
      end else begin
        if (high_cnt > 0) begin
          chk("run_len", high_cnt, lat + 1);
          run_no++;
          high_cnt = 0;
        end
        if (busy_o) low_cnt++;
      end
    end
  end

  task automatic start_scan(input logic [63:0] b, input logic [63:0] k, input logic m,
                            input int fn, input int lt, input bit noise);
    int c;
    fn_sel    = fn;
    lat       = lt;
    gap_noise = noise;
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    base_data_i = b;
    key_i       = k;
    mode_i      = m;
    @(posedge clk);
    #1;
    start_i     = 1'b0;
    base_data_i = {$urandom, $urandom};
    key_i       = {$urandom, $urandom};
    mode_i      = ~m;
    m_base = b;
    m_key  = k;
    m_mode = m;
    exp_q.delete();
    exp_total = 0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      c = $countones(core_f(fn, b ^ (64'd1 << i), k) ^ core_f(fn, b, k));
      exp_q.push_back('{i, c});
      exp_total += c;
    end
    mtot = 0; mmin = 127; mmax = 0;
    run_no = 0; low_cnt = 0; high_cnt = 0; ndone = 0;
    chk_en = 1'b1;
  endtask

  // Waits for done_o, pulsing stray starts while busy; these must be ignored.
  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      if (busy_o && $urandom_range(0, 49) == 0) begin
        #1;
        start_i     = 1'b1;
        base_data_i = {$urandom, $urandom};
        key_i       = {$urandom, $urandom};
        mode_i      = $urandom_range(0, 1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
    end
    if (!ok) chk("scan_done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_enable"}, core_bus.core_enable, 0);
    chk({tag, "_core_data"}, core_bus.core_data, 0);
    chk({tag, "_res_valid"}, res_valid_o, 0);
    chk({tag, "_res_cnt"}, res_cnt_o, 0);
    chk({tag, "_res_idx"}, res_idx_o, 0);
    chk({tag, "_total"}, total_o, 0);
    chk({tag, "_min"}, min_o, 7'h7f);
    chk({tag, "_max"}, max_o, 0);
    chk({tag, "_base_out"}, base_out_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    bit seen_done;
    bit hit;
    logic [63:0] b, k;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Identity core, fixed base: every flip differs in exactly one bit
    start_scan(64'h0123456789abcdef, 64'h0123456789abcdef, 1'b0, 0, 2, 1'b0);
    wait_done(3000);
    chk("id_total", total_o, 64);
    chk("id_min", min_o, 1);
    chk("id_max", max_o, 1);
    chk("id_base_out", base_out_o, 64'h0123456789abcdef);
    chk("id_ndone", ndone, 1);
    chk("id_busy_idle", busy_o, 0);

    // Inverting core, aborted by reset at idx 10
    start_scan(64'hfeedface_cafef00d, 64'h1, 1'b1, 1, 1, 1'b1);
    hit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (res_valid_o && res_idx_o == 10) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_idx10", hit, 1);
    #1;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_done |= done_o;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_idle", busy_o, 0);

    // Clean rerun after abort
    start_scan(64'hfeedface_cafef00d, 64'h1, 1'b1, 1, 1, 1'b1);
    wait_done(3000);
    chk("inv_total", total_o, 64);
    chk("inv_min", min_o, 1);
    chk("inv_base_out", base_out_o, 64'h0112053135010ff2);
    chk("inv_ndone", ndone, 1);

    // Randomised scans across core functions, latencies and stray-ready noise
    for (int s = 0; s < 4; s++) begin
      b = {$urandom, $urandom};
      k = {$urandom, $urandom};
      start_scan(b, k, 1'($urandom_range(0, 1)), (s == 0) ? 3 : int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      wait_done(3000);
      chk("rnd_total", total_o, exp_total);
      chk("rnd_ndone", ndone, 1);
      chk("rnd_base_out", base_out_o, core_f(fn_sel, b, k));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avalanche_scan_ctrl.md
Name: avalanche_scan_ctrl

Overview:
Hardware avalanche-effect analyser that drives any block-cipher core with an enable/mode/ready interface, such as the DES core.
- Runs the core once on a base plaintext, then once per single-bit-flipped plaintext (bit 0 up to bit DATA_W-1).
- For each flipped run, counts the ciphertext bits that differ from the base ciphertext.
- Streams one result per bit and keeps total, minimum and maximum statistics.
- Replaces the software avalanche loop with a synthesizable, width-parametrised scan.

Parameters:
DATA_W, 64, cipher block width in bits (from 8 to 128).
KEY_W, 64, key width in bits.
CNT_W, $clog2(DATA_W+1), width of a per-run differing-bit count.
TOT_W, 16, width of the total-flips accumulator; must satisfy TOT_W >= CNT_W + $clog2(DATA_W).
RST_GAP, 2, number of cycles core_enable_o is held low before each run (range 1 to 15).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start_i  in  1  one-cycle pulse that begins a scan; honoured only in IDLE.
mode_i  in  1  cipher mode: 0 = encrypt, 1 = decrypt; sampled at start_i.
base_data_i  in  DATA_W  base plaintext; sampled at start_i.
key_i  in  KEY_W  key; sampled at start_i.
core_enable_o  out  1  enable to the cipher core.
core_mode_o  out  1  mode to the cipher core.
core_data_o  out  DATA_W  data to the cipher core.
core_key_o  out  KEY_W  key to the cipher core.
core_data_i  in  DATA_W  cipher core output.
core_ready_i  in  1  cipher core ready, level-sensitive.
base_out_o  out  DATA_W  captured base ciphertext.
res_valid_o  out  1  one-cycle pulse marking a per-bit result.
res_idx_o  out  $clog2(DATA_W)  index of the flipped bit.
res_cnt_o  out  CNT_W  number of differing output bits.
total_o  out  TOT_W  running sum of all res_cnt_o values.
min_o  out  CNT_W  minimum res_cnt_o seen in this scan.
max_o  out  CNT_W  maximum res_cnt_o seen in this scan.
busy_o  out  1  high from the cycle after start_i accepted until DONE.
done_o  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (asynchronous, reset=0):
  - State returns to IDLE.
  - All outputs go to 0, except min_o, which goes to all-ones.
  - Reset mid-scan aborts immediately; no done_o is produced.
- States: IDLE, GAP, RUN, CMP, EMIT, DONE.
- IDLE:
  - On start_i, latch mode_i, base_data_i and key_i.
  - Set idx=0 and phase=BASE.
  - Clear total_o and max_o; set min_o to all-ones.
  - Go to GAP.
  - start_i outside IDLE is ignored.
- GAP:
  - core_enable_o=0.
  - core_data_o = base when phase=BASE, otherwise base ^ (1<<idx).
  - core_mode_o and core_key_o carry the latched values; all three core inputs are stable for the whole GAP and RUN.
  - After RST_GAP cycles, go to RUN.
- RUN:
  - core_enable_o=1.
  - The first cycle with core_ready_i=1 captures core_data_i.
  - core_ready_i is ignored whenever core_enable_o=0.
  - No timeout unless the optional feature below is compiled in.
- CMP:
  - If phase=BASE: write the capture to base_out_o, set phase=FLIP, go to GAP.
  - Otherwise: register popcount(capture ^ base_out_o) into res_cnt_o and go to EMIT.
- EMIT:
  - Pulse res_valid_o with res_idx_o=idx.
  - Update total_o, min_o and max_o in the same cycle; their new values are visible the cycle after the pulse.
  - If idx == DATA_W-1, go to DONE; otherwise increment idx and go to GAP.
- DONE: pulse done_o, drop busy_o, go to IDLE.
- Timing:
  - Each run costs RST_GAP + core latency + 1 cycles (+1 in EMIT for flipped runs).
  - Total scan time is (DATA_W+1) runs.
- Arithmetic and retention:
  - All counts are unsigned.
  - total_o saturates at all-ones; it cannot overflow when TOT_W is sized as above.
  - base_out_o and the statistics hold their values after DONE until the next start_i.

Optional Feature:
AVAL_KEY_SCAN_EN
- With the macro defined:
  - Adds input port scan_key_i (1 bit), sampled at start_i.
  - When scan_key_i=1, the scan flips key bits 0 to KEY_W-1 instead of data bits, and data stays at base.
  - res_idx_o widens to $clog2(max(DATA_W,KEY_W)).
  - The scan ends at idx == KEY_W-1.
- Without the macro: the port is absent and only data bits are scanned.

Decomposition:
- Package aval_pkg holds:
  - the state enum;
  - phase constants BASE and FLIP;
  - a function clog2_min1;
  - a parametrised popcount function.
- One sub-module, popcount_tree: DATA_W-wide registered adder tree, one-cycle latency, used in CMP.

Test Plan:
- Identity core model (core_data_i = core_data_o, ready two cycles after enable): base=0x0123456789abcdef.
  - Required: 64 results, each res_cnt_o=1, with res_idx_o running 0 to 63 in order.
  - Final total_o=64, min_o=1, max_o=1; exactly one done_o.
- Real DES core, mode=0, key 0x0123456789abcdef, base 0x3b98d2eeaeb60035.
  - Required: base_out_o = 0x6305e6ff626a4f0b.
  - Every res_cnt_o lies between 20 and 44.
  - total_o equals the sum of the logged res_cnt_o values.
- Inverting core model (core_data_i = ~core_data_o): each res_cnt_o=1.
  - Then assert reset=0 while at idx=10.
  - Required: all outputs cleared, no done_o, and a new start_i runs a full, clean scan.
- start_i pulsed again during RUN: ignored.
  - core_ready_i held high during GAP: no capture occurs.
  - RST_GAP=3: core_enable_o is low for exactly 3 cycles before each run.
- DATA_W=8 with the identity core: 8 results, total_o=8.
  - With AVAL_KEY_SCAN_EN and scan_key_i=1, using an XOR-with-key model: 64 results, each res_cnt_o=1.
